// File: rtl/riscv_pkg.sv
// Shared RV32I definitions used by the integer register file.
//   XLEN       : data width of every register and data port
//   REG_ADDR_W : register address width (2**REG_ADDR_W registers)
//   word_t     : one XLEN-bit register word
//   reg_addr_t : register index
//   REG_ZERO   : index of the hardwired-zero register x0
package riscv_pkg;
    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef logic [XLEN-1:0]       word_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = '0;
endpackage

// File: rtl/register_file_read_port.sv
// One combinational read port of the register file.
// Decodes the address against the x1..x31 storage, forces x0 to zero, and,
// when REGFILE_WRITE_BYPASS_EN is defined, forwards same-cycle write data.
// Ports:
//   regs : flattened storage of x1..x31
//   addr : read address
//   we   : write enable of the write port (bypass only)
//   wa   : write address (bypass only)
//   wd   : write data (bypass only)
//   rd   : read data
// Build option: REGFILE_WRITE_BYPASS_EN enables write-to-read forwarding.
import riscv_pkg::*;

module register_file_read_port #(
    parameter int NREG = 2**REG_ADDR_W
) (
    input  logic [NREG-1:1][XLEN-1:0] regs,
    input  reg_addr_t                 addr,
    input  logic                      we,
    input  reg_addr_t                 wa,
    input  word_t                     wd,
    output word_t                     rd
);
    word_t arr_rd;

    // x0 has no storage, so it must never index the array.
    always_comb begin
        arr_rd = '0;
        if (addr != REG_ZERO)
            arr_rd = regs[addr];
    end

`ifdef REGFILE_WRITE_BYPASS_EN
    // The x0 guard on the write side also keeps x0 reads at zero here.
    assign rd = (we && wa != REG_ZERO && wa == addr) ? wd : arr_rd;
`else
    logic unused_bypass;
    assign unused_bypass = ^{we, wa, wd};
    assign rd = arr_rd;
`endif
endmodule

// File: rtl/register_file.sv
// RV32I integer register file: 32 x XLEN registers, x0 hardwired to zero,
// two asynchronous read ports and one synchronous write port.
// Ports:
//   clk : clock, state updates on rising edge
//   rst : synchronous active-high reset, clears all registers, beats a write
//   a1  : read address 1 (rs1)    rd1 : read data 1
//   a2  : read address 2 (rs2)    rd2 : read data 2
//   a3  : write address (rd)      we3 : write enable   wd3 : write data
// Build option: REGFILE_WRITE_BYPASS_EN forwards wd3 to a read port whose
// address matches a3 in the write cycle (see register_file_read_port).
import riscv_pkg::*;

module register_file #(
    parameter int XLEN_P = XLEN,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] a1,
    input  logic [ADDR_W-1:0] a2,
    input  logic [ADDR_W-1:0] a3,
    input  logic              we3,
    input  logic [XLEN_P-1:0] wd3,
    output logic [XLEN_P-1:0] rd1,
    output logic [XLEN_P-1:0] rd2
);
    localparam int NREG   = 2**ADDR_W;
    localparam int NRD    = 2;

    // x1..x31 only; x0 is synthesised as a constant in the read ports.
    logic [NREG-1:1][XLEN-1:0]   regs;
    logic [NRD-1:0][ADDR_W-1:0]  ra;
    logic [NRD-1:0][XLEN-1:0]    rdat;

    always_ff @(posedge clk) begin
        if (rst)
            regs <= '0;
        else if (we3 && a3 != REG_ZERO)
            regs[a3] <= wd3;
    end

    assign ra  = {a2, a1};
    assign rd1 = rdat[0];
    assign rd2 = rdat[1];

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        register_file_read_port #(.NREG(NREG)) u_port (
            .regs (regs),
            .addr (ra[p]),
            .we   (we3),
            .wa   (a3),
            .wd   (wd3),
            .rd   (rdat[p])
        );
    end
endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: stimulus pushes expected read values,
// a negedge monitor pops and compares them against rd1/rd2.
import riscv_pkg::*;

module tb_register_file;
    logic      clk = 1'b0;
    logic      rst, we3;
    reg_addr_t a1, a2, a3;
    word_t     wd3, rd1, rd2;

    typedef struct {
        int    port;
        word_t v;
        string name;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

`ifdef REGFILE_WRITE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    always #5 clk = ~clk;

    register_file dut (
        .clk(clk), .rst(rst), .a1(a1), .a2(a2), .a3(a3),
        .we3(we3), .wd3(wd3), .rd1(rd1), .rd2(rd2)
    );

    // Monitor: reads are combinational, so every expectation pushed in a
    // cycle is checked at the following negedge.
    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t e;
            word_t act;
            e   = q.pop_front();
            act = (e.port == 1) ? rd1 : rd2;
            checks++;
            if (act !== e.v) begin
                errors++;
                $display("FAIL %s rd%0d got %h want %h", e.name, e.port, act, e.v);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_rd(input int port, input word_t v, input string name);
        exp_t e;
        e.port = port; e.v = v; e.name = name;
        q.push_back(e);
    endtask

    task automatic wr(input reg_addr_t a, input word_t d);
        a3 = a; wd3 = d; we3 = 1'b1;
        cyc();
        we3 = 1'b0;
    endtask

    initial begin
        rst = 1'b1; we3 = 1'b0; a1 = '0; a2 = '0; a3 = '0; wd3 = '0;
        cyc();
        rst = 1'b0;

        // 1. every address reads zero after reset
        for (int i = 0; i < 32; i++) begin
            a1 = reg_addr_t'(i);
            a2 = reg_addr_t'(31 - i);
            expect_rd(1, 32'd0, "reset_rd1");
            expect_rd(2, 32'd0, "reset_rd2");
            cyc();
        end

        // 2. write to x0 is discarded
        wr(5'd0, 32'd200);
        a1 = 5'd0;
        expect_rd(1, 32'd0, "x0_immutable");
        cyc();

        // 3. write x1 (old value visible before the edge unless bypassed)
        a3 = 5'd1; wd3 = 32'd200; we3 = 1'b1; a1 = 5'd1;
        expect_rd(1, BYP ? 32'd200 : 32'd0, "pre_edge_x1");
        cyc();
        we3 = 1'b0;
        expect_rd(1, 32'd200, "write_x1");
        wr(5'd2, 32'd200);
        a2 = 5'd2;
        expect_rd(2, 32'd200, "write_x2");
        cyc();

        // 4. overwrite, then we3=0 must not change anything
        wr(5'd1, 32'd100);
        a1 = 5'd1;
        expect_rd(1, 32'd100, "overwrite_x1");
        a3 = 5'd1; wd3 = 32'd150; we3 = 1'b0;
        cyc();
        expect_rd(1, 32'd100, "we0_hold");
        cyc();

        // 5. swapped ports and a1 == a2
        a1 = 5'd2; a2 = 5'd1;
        expect_rd(1, 32'd200, "swap_rd1");
        expect_rd(2, 32'd100, "swap_rd2");
        cyc();
        a1 = 5'd2; a2 = 5'd2;
        expect_rd(1, 32'd200, "same_addr_rd1");
        expect_rd(2, 32'd200, "same_addr_rd2");
        cyc();

        // top register boundary, neighbour untouched
        wr(5'd31, 32'hFFFF_FFFF);
        a1 = 5'd31; a2 = 5'd30;
        expect_rd(1, 32'hFFFF_FFFF, "write_x31");
        expect_rd(2, 32'd0, "x30_untouched");
        cyc();

        // 6. reset beats a simultaneous write
        wr(5'd5, 32'h0000_1234);
        a1 = 5'd5;
        expect_rd(1, 32'h0000_1234, "write_x5");
        cyc();
        rst = 1'b1; we3 = 1'b1; a3 = 5'd5; wd3 = 32'hDEAD_BEEF;
        cyc();
        rst = 1'b0; we3 = 1'b0;
        a1 = 5'd5; a2 = 5'd1;
        expect_rd(1, 32'd0, "rst_over_write_x5");
        expect_rd(2, 32'd0, "rst_clears_x1");
        cyc();
        a1 = 5'd31;
        expect_rd(1, 32'd0, "rst_clears_x31");
        cyc();

        // bypass window: forwarded only in the bypass build, never for x0
        a1 = 5'd5; a3 = 5'd5; we3 = 1'b1; wd3 = 32'd7; a2 = 5'd0;
        expect_rd(1, BYP ? 32'd7 : 32'd0, "bypass_x5");
        expect_rd(2, 32'd0, "bypass_other_port");
        cyc();
        we3 = 1'b0;
        expect_rd(1, 32'd7, "after_edge_x5");
        cyc();
        a1 = 5'd0; a3 = 5'd0; we3 = 1'b1; wd3 = 32'd9;
        expect_rd(1, 32'd0, "bypass_x0");
        cyc();
        we3 = 1'b0;

        // let the monitor drain, bounded
        for (int t = 0; t < 4 && q.size() > 0; t++) cyc();
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain pending %0d want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
endmodule
